// File: rtl/full_adder.sv
// full_adder: parameterised ripple-carry adder built from 1-bit full-adder cells.
// The combinational result {cout,sum} = a + b + cin is always present.
// Optional feature macro: FULL_ADDER_REG_EN adds a one-cycle registered copy
// (sum_q/cout_q) qualified by in_valid/out_valid. Without it, clk/rst_n are unused.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_REG_EN
    ,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
`endif
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] carry;
    logic [WIDTH-1:0] prop;

    assign carry[0] = cin;

    // One full-adder cell per bit; the carry ripples LSB to MSB.
    // No X masking: unknown inputs propagate naturally through the gates.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign prop[gi]      = a[gi] ^ b[gi];
            assign sum[gi]       = prop[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & prop[gi]);
        end
    endgenerate

    assign cout = carry[WIDTH];

`ifdef FULL_ADDER_REG_EN
    logic [WIDTH-1:0] sum_q_reg;
    logic             cout_q_reg;
    logic             out_valid_reg;

    // Capture the combinational result when qualified; hold it otherwise.
    // Reset clears everything immediately, discarding any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q_reg     <= '0;
            cout_q_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                sum_q_reg  <= sum;
                cout_q_reg <= cout;
            end
        end
    end

    assign sum_q     = sum_q_reg;
    assign cout_q    = cout_q_reg;
    assign out_valid = out_valid_reg;
`else
    // Clock and reset are kept on the port list for a uniform footprint but
    // drive nothing in the purely combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder at WIDTH=1, 8 and 4.
// Registered-stage checks are included when FULL_ADDER_REG_EN is defined.
`timescale 1ns/1ps
module tb_full_adder;

    logic clk;
    logic rst_n;

    // WIDTH=1 instance
    logic       a1, b1, cin1;
    logic       sum1;
    logic       cout1;
    // WIDTH=8 instance
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       cout8;
    // WIDTH=4 instance
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4;
`ifdef FULL_ADDER_REG_EN
    logic       iv1, iv8, iv4;
    logic       sq1;
    logic       cq1, ov1;
    logic [7:0] sq8;
    logic       cq8, ov8;
    logic [3:0] sq4;
    logic       cq4, ov4;
`endif

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1)
`ifdef FULL_ADDER_REG_EN
        , .in_valid(iv1), .sum_q(sq1), .cout_q(cq1), .out_valid(ov1)
`endif
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
`ifdef FULL_ADDER_REG_EN
        , .in_valid(iv8), .sum_q(sq8), .cout_q(cq8), .out_valid(ov8)
`endif
    );

    full_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4)
`ifdef FULL_ADDER_REG_EN
        , .in_valid(iv4), .sum_q(sq4), .cout_q(cq4), .out_valid(ov4)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Hand-computed {sum,cout} for (a,b,cin) = 000..111.
    logic [1:0] w1_exp [8];
    logic [2:0] vec;
    logic [8:0] exp9;

    initial begin
        checks   = 0;
        failures = 0;
        w1_exp[0] = 2'b00; w1_exp[1] = 2'b10; w1_exp[2] = 2'b10; w1_exp[3] = 2'b01;
        w1_exp[4] = 2'b10; w1_exp[5] = 2'b01; w1_exp[6] = 2'b01; w1_exp[7] = 2'b11;

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
`ifdef FULL_ADDER_REG_EN
        iv1 = 1'b0; iv8 = 1'b0; iv4 = 1'b0;
`endif
        #1;
        // Combinational path works during reset.
        a4 = 4'h7; b4 = 4'h2; cin4 = 1'b0;
        #1;
        $display("txn reset_comb a=7 b=2 cin=0 sum=%0h cout=%0b", sum4, cout4);
        check("reset_comb_sum", 32'(sum4), 32'h9);
        check("reset_comb_cout", 32'(cout4), 32'h0);
`ifdef FULL_ADDER_REG_EN
        check("reset_sum_q", 32'(sq4), 32'h0);
        check("reset_cout_q", 32'(cq4), 32'h0);
        check("reset_out_valid", 32'(ov4), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive, one vector per 10 ns.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vec = 3'(i);
            a1 = vec[2]; b1 = vec[1]; cin1 = vec[0];
            #1;
            $display("txn w1 a=%0b b=%0b cin=%0b sum=%0b cout=%0b", a1, b1, cin1, sum1, cout1);
            check($sformatf("w1_vec%0d", i), 32'({sum1, cout1}), 32'(w1_exp[i]));
        end

        // WIDTH=8 boundary vectors.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
        $display("txn w8 a=ff b=00 cin=1 sum=%0h cout=%0b", sum8, cout8);
        check("w8_max_plus_1_sum", 32'(sum8), 32'h00);
        check("w8_max_plus_1_cout", 32'(cout8), 32'h1);
        a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b0; #1;
        $display("txn w8 a=5a b=a5 cin=0 sum=%0h cout=%0b", sum8, cout8);
        check("w8_5a_a5_sum", 32'(sum8), 32'hFF);
        check("w8_5a_a5_cout", 32'(cout8), 32'h0);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
        $display("txn w8 a=ff b=ff cin=1 sum=%0h cout=%0b", sum8, cout8);
        check("w8_all_ones_sum", 32'(sum8), 32'hFF);
        check("w8_all_ones_cout", 32'(cout8), 32'h1);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; #1;
        $display("txn w8 a=80 b=80 cin=0 sum=%0h cout=%0b", sum8, cout8);
        check("w8_msb_carry_sum", 32'(sum8), 32'h00);
        check("w8_msb_carry_cout", 32'(cout8), 32'h1);

        // WIDTH=8 random vectors against the arithmetic definition.
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            #1;
            exp9 = 9'(a8) + 9'(b8) + 9'(cin8);
            $display("txn w8_rand%0d a=%0h b=%0h cin=%0b sum=%0h cout=%0b", i, a8, b8, cin8, sum8, cout8);
            check($sformatf("w8_rand%0d", i), 32'({cout8, sum8}), 32'(exp9));
        end

        // Toggling reset must not disturb the combinational result.
        @(negedge clk);
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        $display("txn w4_rst_comb a=f b=0 cin=1 sum=%0h cout=%0b", sum4, cout4);
        check("w4_rst_comb_sum", 32'(sum4), 32'h0);
        check("w4_rst_comb_cout", 32'(cout4), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef FULL_ADDER_REG_EN
        // Capture 3+4+1 with one-cycle latency.
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1; iv4 = 1'b1;
        @(posedge clk); #1;
        $display("txn w4_reg cap sum_q=%0h cout_q=%0b ov=%0b", sq4, cq4, ov4);
        check("reg_cap_sum_q", 32'(sq4), 32'h8);
        check("reg_cap_cout_q", 32'(cq4), 32'h0);
        check("reg_cap_out_valid", 32'(ov4), 32'h1);
        // Idle cycle: valid drops, data holds.
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0;
        @(posedge clk); #1;
        $display("txn w4_reg idle sum_q=%0h cout_q=%0b ov=%0b", sq4, cq4, ov4);
        check("reg_idle_sum_q", 32'(sq4), 32'h8);
        check("reg_idle_out_valid", 32'(ov4), 32'h0);
        // Back-to-back captures: 9+9 then F+F+1.
        @(negedge clk);
        iv4 = 1'b1;
        @(posedge clk); #1;
        check("reg_b2b1_sum_q", 32'({cq4, sq4}), 32'h12);
        check("reg_b2b1_out_valid", 32'(ov4), 32'h1);
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        @(posedge clk); #1;
        $display("txn w4_reg b2b sum_q=%0h cout_q=%0b ov=%0b", sq4, cq4, ov4);
        check("reg_b2b2_sum_q", 32'({cq4, sq4}), 32'h1F);
        check("reg_b2b2_out_valid", 32'(ov4), 32'h1);
        // Asynchronous reset between edges clears registers immediately.
        @(negedge clk);
        a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn w4_reg async_rst sum_q=%0h cout_q=%0b ov=%0b sum=%0h", sq4, cq4, ov4, sum4);
        check("reg_arst_sum_q", 32'(sq4), 32'h0);
        check("reg_arst_cout_q", 32'(cq4), 32'h0);
        check("reg_arst_out_valid", 32'(ov4), 32'h0);
        check("reg_arst_comb_sum", 32'({cout4, sum4}), 32'h05);
        @(posedge clk); #1;
        check("reg_in_rst_out_valid", 32'(ov4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn w4_reg post_rst sum_q=%0h cout_q=%0b ov=%0b", sq4, cq4, ov4);
        check("reg_post_rst_sum_q", 32'({cq4, sq4}), 32'h05);
        check("reg_post_rst_out_valid", 32'(ov4), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
